// File: rtl/uart_pkg.sv
// Shared UART datapath defaults and the character word type.
package uart_pkg;

  localparam int UART_DATA_SIZE  = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef logic [UART_DATA_SIZE-1:0] uart_word_t;

endpackage

// File: rtl/uart_fifo_ptr.sv
// Mod-DEPTH wrap counter used for the FIFO write and read pointers.
module uart_fifo_ptr #(
  parameter int DEPTH = 16,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] ptr_reg;

  // Explicit wrap at DEPTH-1 so any depth works, not only powers of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (clr) begin
      ptr_reg <= '0;
    end else if (inc) begin
      ptr_reg <= (ptr_reg == LAST) ? '0 : ptr_reg + 1'b1;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/uart_fifo_lvl.sv
// UART character FIFO with arbitrary depth, fill level, almost flags,
// sticky overflow/underflow and a synchronous flush.
module uart_fifo_lvl
  import uart_pkg::*;
#(
  parameter int DATA_SIZE = UART_DATA_SIZE,
  parameter int DEPTH     = UART_FIFO_DEPTH,
  parameter int AF_LEVEL  = DEPTH - 2,
  parameter int AE_LEVEL  = 1,
  parameter int LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 clr,
  input  logic [DATA_SIZE-1:0] w_data,
  input  logic                 wr,
  input  logic                 rd,
  output logic [DATA_SIZE-1:0] r_data,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [LVL_W-1:0]     level,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AF_L    = LVL_W'(AF_LEVEL);
  localparam logic [LVL_W-1:0] AE_L    = LVL_W'(AE_LEVEL);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     w_ptr;
  logic [PTR_W-1:0]     r_ptr;

  logic [LVL_W-1:0] level_reg, level_next;
  logic             full_reg, empty_reg, af_reg, ae_reg;
  logic             ovf_reg, unf_reg;
  logic             wr_acc, rd_acc, wr_rej, rd_rej;

  // A full FIFO still accepts a write when a read frees a slot in the same tick.
  assign wr_acc = s_tick && !clr && wr && (!full_reg || rd);
  assign rd_acc = s_tick && !clr && rd && !empty_reg;
  assign wr_rej = s_tick && wr && full_reg && !rd;
  assign rd_rej = s_tick && rd && empty_reg;

  always_comb begin
    level_next = level_reg;
    if (clr) begin
      level_next = '0;
    end else begin
      level_next = level_reg + LVL_W'(wr_acc) - LVL_W'(rd_acc);
    end
  end

  uart_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (wr_acc),
    .ptr   (w_ptr)
  );

  uart_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (rd_acc),
    .ptr   (r_ptr)
  );

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[w_ptr] <= w_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_reg <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
      af_reg    <= 1'b0;
      ae_reg    <= 1'b1;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      level_reg <= level_next;
      full_reg  <= (level_next == DEPTH_L);
      empty_reg <= (level_next == '0);
      af_reg    <= (level_next >= AF_L);
      ae_reg    <= (level_next <= AE_L);
      if (clr) begin
        ovf_reg <= 1'b0;
        unf_reg <= 1'b0;
      end else begin
        ovf_reg <= ovf_reg || wr_rej;
        unf_reg <= unf_reg || rd_rej;
      end
    end
  end

  assign r_data       = empty_reg ? '0 : mem[r_ptr];
  assign level        = level_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = af_reg;
  assign almost_empty = ae_reg;
  assign overflow     = ovf_reg;
  assign underflow    = unf_reg;

endmodule

// File: doc/uart_fifo_lvl.md
# uart_fifo_lvl

Parametrised successor to the UART byte FIFO. It buffers characters between the UART datapath (rx deserialiser or tx source) and the host side, with:
- arbitrary (non-power-of-two) depth;
- fill-level and almost-full/almost-empty outputs for interrupt and flow-control logic;
- sticky overflow/underflow error flags;
- a synchronous flush;
- defined simultaneous read/write behaviour at the full and empty boundaries.

It keeps the `s_tick` operation enable, so it drops into the existing UART datapath unchanged.

## Interface
Parameters:
- `DATA_SIZE`, 8, word width in bits (≥1).
- `DEPTH`, 16, number of entries (≥2, any integer).
- `AF_LEVEL`, `DEPTH-2`, `almost_full` asserts when `level >= AF_LEVEL` (1..DEPTH).
- `AE_LEVEL`, 1, `almost_empty` asserts when `level <= AE_LEVEL` (0..DEPTH-1).
- `LVL_W`, `$clog2(DEPTH+1)`, width of `level` (derived; do not override).

Ports:
- `clk`, in, 1, clock. One clock only; reset is asynchronous and active-high.
- `reset`, in, 1, asynchronous active-high reset.
- `s_tick`, in, 1, operation enable. `wr` and `rd` are sampled only when it is 1.
- `clr`, in, 1, synchronous flush. Acts independently of `s_tick`.
- `w_data`, in, DATA_SIZE, write data.
- `wr`, in, 1, write request.
- `rd`, in, 1, read request (pop).
- `r_data`, out, DATA_SIZE, head-of-queue word (show-ahead); 0 when empty.
- `full`, out, 1, level == DEPTH.
- `empty`, out, 1, level == 0.
- `almost_full`, out, 1, level ≥ AF_LEVEL.
- `almost_empty`, out, 1, level ≤ AE_LEVEL.
- `level`, out, LVL_W, number of stored words.
- `overflow`, out, 1, sticky: a write was rejected.
- `underflow`, out, 1, sticky: a read was rejected.

## Operation
- An operation occurs on a rising `clk` edge with `s_tick`=1. With `s_tick`=0, only `clr` acts.
- Write accepted iff `wr` && (!full || rd). The word is stored at the write pointer and the write pointer advances.
- Read accepted iff `rd` && !empty. The read pointer advances.
- Boundary cases for `wr`+`rd` in the same tick:
  - Empty: write only is accepted. The read is rejected and `underflow` sets.
  - Full: both are accepted. The level stays at DEPTH and the new word takes the freed slot.
  - Otherwise: both are accepted and the level is unchanged.
- Rejected operations:
  - A rejected write (full, no `rd`) leaves the FIFO unchanged and sets `overflow`.
  - A rejected read (empty) leaves the FIFO unchanged and sets `underflow`.
- Pointers count 0..DEPTH-1 and wrap to 0 after DEPTH-1. There is no power-of-two assumption.
- Level update: `level_next = level + wr_acc - rd_acc`. The level never leaves 0..DEPTH.
- `full`, `empty`, `almost_*` and `level` are all registered. The flags are decoded from `level_next`, so they agree with `level` every cycle.
- `clr` has priority over `wr`/`rd`:
  - Pointers and level go to 0, `empty`=1, `overflow`/`underflow`=0.
  - Memory contents are not cleared.
- Reset values: `level`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0, `overflow`=0, `underflow`=0, `r_data`=0. The storage array is not reset.
- Reset mid-operation: state is discarded immediately. The first accepted write after release lands at index 0.

## Timing
- `r_data` is a combinational read of `mem[r_ptr]`, gated to 0 when `empty`.
- Write→read latency: a word written at edge N appears on `r_data` after edge N if the FIFO was empty. A read may pop it at edge N+1.
- A pop at edge N presents the next word on `r_data` after edge N.
- All status outputs change only on `clk` edges. There are no combinational paths from `wr`/`rd` to any output.
- `overflow`/`underflow` assert the edge after the offending request and hold until `clr` or `reset`.

## Structure
- Shared package `uart_pkg`: `UART_DATA_SIZE`=8 and `UART_FIFO_DEPTH`=16 defaults, plus a typedef `uart_word_t`.
- One sub-module, `uart_fifo_ptr`:
  - Parameter DEPTH; ports `clk`, `reset`, `clr`, `inc`; output `ptr`.
  - Mod-DEPTH wrap counter, instantiated twice (write and read).
- The storage array is an inferred register file in the top module. It is written only on accepted writes.

## Test plan
- Reset, then DEPTH=5 and 5 ticked writes of 0x11..0x15 → `level` 1,2,3,4,5; `full`=1 after the 5th; `almost_full` (AF=3) from the 3rd.
- Full (DEPTH=5) + a 6th write 0xAA without `rd` → `level` stays 5, `overflow`=1, then 5 reads return 0x11..0x15 in order.
- Empty + simultaneous `wr`(0x5A)/`rd` → `level`=1, `r_data`=0x5A, `underflow`=1.
- Full + simultaneous `wr`(0x99)/`rd` → `level` stays 5, next five reads yield the old words 2..5 then 0x99.
- Wrap-around: 12 write/read pairs at depth 5 → data order preserved across the pointer wrap from 4 to 0.
- `wr` with `s_tick`=0 → no change. `clr` while `level`=3 with `overflow` set → next cycle `level`=0, `empty`=1, `overflow`=0, `r_data`=0.
